// File: rtl/x_iddr_pkg.sv
// Shared types and elaboration helpers for the DDR input deserializer.
// Imported by x_iddr_cap and x_iddr_deser.
package x_iddr_pkg;

  // Phase of the rise/fall pairing: EVEN pairs (r[t], f[t]), ODD pairs (f[t-1], r[t]).
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  function automatic int cnt_width(input int ratio);
    int w;
    w = 1;
    while ((1 << w) < (ratio / 2)) begin
      w++;
    end
    return w;
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio >= 2) && ((ratio % 2) == 0);
  endfunction

endpackage

// File: rtl/x_iddr_cap.sv
// Per-pin DDR capture: rise, fall and held-fall flops plus the pairing mux.
// o_pair[0] is the earlier bit of the pair, o_pair[1] the later one.
module x_iddr_cap
  import x_iddr_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic       i_c,
  input  logic       i_rn,
  input  logic       i_ce,
  input  logic       i_d,
  input  logic       i_odd,
  output logic [1:0] o_pair
);

  logic r_rise;
  logic r_fall;
  logic r_fall_hold;

  always_ff @(posedge i_c or negedge i_rn) begin
    if (!i_rn) begin
      r_rise      <= INIT;
      r_fall_hold <= INIT;
    end else if (i_ce) begin
      r_rise      <= i_d;
      r_fall_hold <= r_fall;
    end
  end

  // The falling-edge sample is free-running; only rising-edge logic honours CE.
  always_ff @(negedge i_c or negedge i_rn) begin
    if (!i_rn) begin
      r_fall <= INIT;
    end else begin
      r_fall <= i_d;
    end
  end

  always_comb begin
    o_pair = {r_fall, r_rise};
    if (i_odd) begin
      o_pair = {r_rise, r_fall_hold};
    end
  end

endmodule

// File: rtl/x_iddr_deser.sv
// DDR input deserializer: pairs rise/fall samples per pin and assembles RATIO-bit
// words per pin with a shared counter, phase (bitslip) state and valid strobe.
module x_iddr_deser
  import x_iddr_pkg::*;
#(
  parameter int   DW    = 1,
  parameter int   RATIO = 4,
  parameter logic INIT  = 1'b0
) (
  input  logic                C,
  input  logic                RN,
  input  logic                CE,
  input  logic [DW-1:0]       D,
  input  logic                BITSLIP,
  output logic [DW*RATIO-1:0] Q,
  output logic                Q_VALID
);

  localparam int              HALF     = RATIO / 2;
  localparam int              CW       = cnt_width(RATIO);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HALF - 1);

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("x_iddr_deser: RATIO must be even and at least 2");
  end

  phase_t              r_phase;
  phase_t              w_phase_next;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_next;
  logic                r_primed;
  logic [DW*RATIO-1:0] r_shift;
  logic [DW*RATIO-1:0] w_word;
  logic                w_odd;
  logic                w_accept;
  logic                w_shift;
  logic                w_done;

  assign w_odd = (r_phase == PH_ODD);

  for (genvar gi = 0; gi < DW; gi++) begin : g_pin
    logic [1:0] w_pair;

    x_iddr_cap #(
      .INIT(INIT)
    ) u_cap (
      .i_c   (C),
      .i_rn  (RN),
      .i_ce  (CE),
      .i_d   (D[gi]),
      .i_odd (w_odd),
      .o_pair(w_pair)
    );

    // New pair enters at the top so the earliest bit drifts down to bit 0.
    assign w_word[gi*RATIO +: RATIO] = RATIO'({w_pair, r_shift[gi*RATIO +: RATIO]} >> 2);
  end

  // The first enabled edge after reset only fills the rise flop; pairing starts after it.
  always_comb begin
    w_accept     = CE && r_primed;
    w_shift      = w_accept && !(BITSLIP && !w_odd);
    w_done       = w_shift && (r_cnt == CNT_LAST);
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt;
    if (w_accept && BITSLIP) begin
      w_phase_next = w_odd ? PH_EVEN : PH_ODD;
    end
    if (w_done) begin
      w_cnt_next = '0;
    end else if (w_shift) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      r_phase  <= PH_EVEN;
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_shift  <= '0;
      Q        <= '0;
      Q_VALID  <= 1'b0;
    end else begin
      Q_VALID <= w_done;
      if (CE) begin
        r_primed <= 1'b1;
        r_phase  <= w_phase_next;
        r_cnt    <= w_cnt_next;
        if (w_shift) begin
          r_shift <= w_word;
        end
        if (w_done) begin
          Q <= w_word;
        end
      end
    end
  end

endmodule
